// File: rtl/mword_seq_pkg.sv
// Shared definitions for the multi-word sequencer and the single-word ALU it drives.
package mword_seq_pkg;

  localparam int AC_N = 4;
  localparam logic [AC_N-1:0] AC_AD = 4'd0;
  localparam logic [AC_N-1:0] AC_SB = 4'd1;
  localparam logic [AC_N-1:0] AC_AN = 4'd2;
  localparam logic [AC_N-1:0] AC_OR = 4'd3;

  localparam int MW_W = 3;
  typedef enum logic [MW_W-1:0] {
    MW_ADD = 3'd0,
    MW_SUB = 3'd1,
    MW_AND = 3'd2,
    MW_OR  = 3'd3,
    MW_LT  = 3'd4
  } mw_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } mw_state_e;

endpackage

// File: rtl/mword_shreg.sv
// Operand pair shift register: loads W words, shifts right one word per step, word 0 is current.
module mword_shreg #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_load,
  input  logic           i_shift,
  input  logic [W*N-1:0] i_a,
  input  logic [W*N-1:0] i_b,
  output logic [N-1:0]   o_a_word,
  output logic [N-1:0]   o_b_word
);

  localparam int WN = W * N;

  logic [WN-1:0] r_a;
  logic [WN-1:0] r_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (i_load) begin
      r_a <= i_a;
      r_b <= i_b;
    end else if (i_shift) begin
      r_a <= {{N{1'b0}}, r_a[WN-1:N]};
      r_b <= {{N{1'b0}}, r_b[WN-1:N]};
    end
  end

  assign o_a_word = r_a[N-1:0];
  assign o_b_word = r_b[N-1:0];

endmodule

// File: rtl/mword_seq.sv
// Multi-word sequencer: drives an external ALU word by word, LSW first, chaining carry.
// Optional signed-overflow output enabled by defining MWSEQ_OVF_EN.
module mword_seq
  import mword_seq_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [W*N-1:0]  a,
  input  logic [W*N-1:0]  b,
  output logic            busy,
  output logic            done,
  output logic [W*N-1:0]  result,
  output logic            carry,
  output logic            zero,
`ifdef MWSEQ_OVF_EN
  output logic            ovf,
`endif
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic            alu_cin,
  output logic [AC_N-1:0] alu_cs,
  input  logic [N-1:0]    alu_s,
  input  logic            alu_zero,
  input  logic            alu_cout
);

  localparam int WN = W * N;
  localparam int KW = $clog2(W);
  localparam logic [KW-1:0] K_LAST = KW'(W - 1);

  mw_state_e     r_state;
  mw_op_e        r_op;
  logic [KW-1:0] r_k;
  logic          r_cy;
  logic          r_zacc;
  logic          r_busy;
  logic          r_done;
  logic          r_carry;
  logic          r_zero;
  logic [WN-1:0] r_result;

  logic          w_accept;
  logic          w_run;
  logic          w_arith;
  logic          w_last;
  logic [N-1:0]  w_a_word;
  logic [N-1:0]  w_b_word;

  assign w_accept = (r_state == ST_IDLE) && start && (op <= MW_LT);
  assign w_run    = (r_state == ST_RUN);
  assign w_arith  = (r_op == MW_ADD) || (r_op == MW_SUB) || (r_op == MW_LT);
  assign w_last   = w_run && (r_k == K_LAST);

  mword_shreg #(
    .N(N),
    .W(W)
  ) u_shreg (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_load   (w_accept),
    .i_shift  (w_run),
    .i_a      (a),
    .i_b      (b),
    .o_a_word (w_a_word),
    .o_b_word (w_b_word)
  );

  // Outside RUN the ALU sees a benign AND of zeros.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_cs  = AC_AN;
    if (w_run) begin
      alu_a   = w_a_word;
      alu_b   = w_b_word;
      alu_cin = w_arith & r_cy;
      case (r_op)
        MW_ADD:        alu_cs = AC_AD;
        MW_SUB, MW_LT: alu_cs = AC_SB;
        MW_OR:         alu_cs = AC_OR;
        default:       alu_cs = AC_AN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= MW_AND;
      r_k      <= '0;
      r_cy     <= 1'b0;
      r_zacc   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b1;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= mw_op_e'(op);
            r_k     <= '0;
            r_cy    <= 1'b0;
            r_zacc  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_cy   <= w_arith & alu_cout;
          r_zacc <= r_zacc & alu_zero;
          r_k    <= r_k + 1'b1;
          if (r_k == K_LAST) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_carry <= w_arith & alu_cout;
            if (r_op == MW_LT) begin
              r_result <= {{(WN-1){1'b0}}, alu_cout};
              r_zero   <= ~alu_cout;
            end else begin
              r_result <= {alu_s, r_result[WN-1:N]};
              r_zero   <= r_zacc & alu_zero;
            end
          end else begin
            r_result <= {alu_s, r_result[WN-1:N]};
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign carry  = r_carry;
  assign zero   = r_zero;

`ifdef MWSEQ_OVF_EN
  logic r_ovf;
  logic w_ovf;

  // Sign bits of the top word are on the ALU ports during the last RUN cycle.
  always_comb begin
    w_ovf = 1'b0;
    case (r_op)
      MW_ADD:        w_ovf = (alu_a[N-1] == alu_b[N-1]) && (alu_s[N-1] != alu_a[N-1]);
      MW_SUB, MW_LT: w_ovf = (alu_a[N-1] != alu_b[N-1]) && (alu_s[N-1] != alu_a[N-1]);
      default:       w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_mword_seq.sv
// Directed bench for mword_seq with an 8-bit ALU model and a whole-operand reference model.
module tb_mword_seq;
  import mword_seq_pkg::*;

  localparam int N  = 8;
  localparam int W  = 4;
  localparam int WN = W * N;

  logic            clk   = 1'b0;
  logic            rst   = 1'b1;
  logic            start = 1'b0;
  logic [2:0]      op    = 3'd0;
  logic [WN-1:0]   a     = '0;
  logic [WN-1:0]   b     = '0;
  logic            busy, done, carry, zero;
  logic [WN-1:0]   result;
`ifdef MWSEQ_OVF_EN
  logic            ovf;
`endif
  logic [N-1:0]    alu_a, alu_b, alu_s;
  logic            alu_cin, alu_zero, alu_cout;
  logic [AC_N-1:0] alu_cs;
  logic [N:0]      alu_t;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mword_seq #(
    .N(N),
    .W(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
`ifdef MWSEQ_OVF_EN
    .ovf      (ovf),
`endif
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_cs   (alu_cs),
    .alu_s    (alu_s),
    .alu_zero (alu_zero),
    .alu_cout (alu_cout)
  );

  // Single-word ALU; for subtract, carry out is the borrow.
  always_comb begin
    alu_t = '0;
    case (alu_cs)
      AC_AD:   alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};
      AC_SB:   alu_t = {1'b0, alu_a} - {1'b0, alu_b} - {{N{1'b0}}, alu_cin};
      AC_AN:   alu_t = {1'b0, alu_a & alu_b};
      AC_OR:   alu_t = {1'b0, alu_a | alu_b};
      default: alu_t = '0;
    endcase
  end
  assign alu_s    = alu_t[N-1:0];
  assign alu_cout = alu_t[N];
  assign alu_zero = (alu_s == '0);

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [WN-1:0] calc_r(input logic [2:0] o, input logic [WN-1:0] x, input logic [WN-1:0] y);
    case (o)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return x & y;
      3'd3:    return x | y;
      default: return (x < y) ? WN'(1) : WN'(0);
    endcase
  endfunction

  function automatic logic calc_c(input logic [2:0] o, input logic [WN-1:0] x, input logic [WN-1:0] y);
    logic [WN:0] s;
    s = {1'b0, x} + {1'b0, y};
    case (o)
      3'd0:       return s[WN];
      3'd1, 3'd4: return x < y;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic calc_v(input logic [2:0] o, input logic [WN-1:0] x, input logic [WN-1:0] y);
    logic [WN-1:0] s, d;
    s = x + y;
    d = x - y;
    case (o)
      3'd0:       return (x[WN-1] == y[WN-1]) && (s[WN-1] != x[WN-1]);
      3'd1, 3'd4: return (x[WN-1] != y[WN-1]) && (d[WN-1] != x[WN-1]);
      default:    return 1'b0;
    endcase
  endfunction

  // Transaction-level model: count cycles since acceptance, publish results at completion.
  int            m_cnt = 0;
  logic [WN-1:0] m_a = '0, m_b = '0;
  logic [2:0]    m_op = 3'd0;
  logic          e_busy = 1'b0, e_done = 1'b0, e_carry = 1'b0, e_zero = 1'b1, e_ovf = 1'b0;
  logic [WN-1:0] e_result = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt    <= 0;
      e_busy   <= 1'b0;
      e_done   <= 1'b0;
      e_carry  <= 1'b0;
      e_zero   <= 1'b1;
      e_ovf    <= 1'b0;
      e_result <= '0;
    end else if (m_cnt == 0) begin
      if (start && op <= 3'd4) begin
        m_cnt  <= 1;
        m_a    <= a;
        m_b    <= b;
        m_op   <= op;
        e_busy <= 1'b1;
      end
    end else if (m_cnt == W) begin
      m_cnt    <= W + 1;
      e_done   <= 1'b1;
      e_result <= calc_r(m_op, m_a, m_b);
      e_carry  <= calc_c(m_op, m_a, m_b);
      e_zero   <= (calc_r(m_op, m_a, m_b) == '0);
      e_ovf    <= calc_v(m_op, m_a, m_b);
    end else if (m_cnt == W + 1) begin
      m_cnt  <= 0;
      e_busy <= 1'b0;
      e_done <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      if (!e_busy || e_done) begin
        chk("result", result, e_result);
        chk("carry", carry, e_carry);
        chk("zero", zero, e_zero);
`ifdef MWSEQ_OVF_EN
        chk("ovf", ovf, e_ovf);
`endif
        chk("alu_a_idle", alu_a, '0);
        chk("alu_b_idle", alu_b, '0);
        chk("alu_cin_idle", alu_cin, 1'b0);
        chk("alu_cs_idle", alu_cs, AC_AN);
      end
    end
  end

  task automatic wait_done(input string nm, output int lat);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, W + 1);
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [WN-1:0] x, input logic [WN-1:0] y,
                        input logic [WN-1:0] er, input logic ec, input logic ez, input logic ev);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    wait_done(nm, lat);
    chk({nm, "_res"}, result, er);
    chk({nm, "_model_res"}, e_result, er);
    chk({nm, "_carry"}, carry, ec);
    chk({nm, "_model_carry"}, e_carry, ec);
    chk({nm, "_zero"}, zero, ez);
`ifdef MWSEQ_OVF_EN
    chk({nm, "_ovf"}, ovf, ev);
    chk({nm, "_model_ovf"}, e_ovf, ev);
`else
    if (ev) chk({nm, "_model_ovf"}, e_ovf, ev);
`endif
    @(negedge clk);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_zero", zero, 1'b1);
    rst = 1'b0;
    cmp_en = 1'b1;

    run_op("add_ff",   3'd0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    run_op("add_ovf",  3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    run_op("sub_neg",  3'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("sub_eq",   3'd1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf",  3'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    run_op("lt_true",  3'd4, 32'h0000_FFFF, 32'h0001_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    run_op("lt_false", 3'd4, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    run_op("and",      3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
    run_op("or",       3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);

    // Illegal op code: nothing happens.
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 32'h1; b = 32'h2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("op6_busy", busy, 1'b0);
      chk("op6_done", done, 1'b0);
      @(negedge clk);
    end

    // A second start during RUN is ignored.
    start = 1'b1; op = 3'd0; a = 32'h1111_1111; b = 32'h2222_2222;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("midrun_latency", lat, W + 1);
    chk("midrun_res", result, 32'h3333_3333);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk("midrun_no_restart", busy, 1'b0);
      @(negedge clk);
    end

    // Reset while word k=2 is in progress.
    start = 1'b1; op = 3'd0; a = 32'h0101_0101; b = 32'h0101_0101;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_result", result, '0);
    chk("abort_zero", zero, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_done", done, 1'b0);
      @(negedge clk);
    end

    run_op("post_rst", 3'd0, 32'h0101_0101, 32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0, 1'b0);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mword_seq.md
# mword_seq

Multi-word operation sequencer that sits directly upstream of the single-word `alu`. It accepts W-word operands and drives the ALU one N-bit word per cycle, least-significant word first, chaining `carry_out` back into `carry_in`. It collects the word results into a W·N-bit result with aggregate carry and zero flags. Calculator arithmetic wider than the datapath word goes through this block.

## Interface
Parameters:
- `N`, 8, ALU word width (must match the attached `alu`)
- `W`, 4, words per operand, ≥2
- `AC_N`, from shared package, ALU op-code width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock; synchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `op`  in  3  MW_ADD=0, MW_SUB=1, MW_AND=2, MW_OR=3, MW_LT=4
- `a`, `b`  in  W·N  operands, captured on accepted `start`
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse; outputs are valid from that cycle on
- `result`  out  W·N  held until next completion
- `carry`  out  1  final carry (ADD) / borrow (SUB, LT); 0 for AND/OR
- `zero`  out  1  1 iff `result` == 0
- `ovf`  out  1  signed overflow (only with MWSEQ_OVF_EN)
- `alu_a`, `alu_b`  out  N  word operands to ALU
- `alu_cin`  out  1  ALU carry_in
- `alu_cs`  out  AC_N  ALU op code
- `alu_s`  in  N;  `alu_zero`  in  1;  `alu_cout`  in  1  ALU results (combinational)

## Operation
- States: IDLE → RUN (W cycles, word index k=0..W-1) → DONE (1 cycle) → IDLE.
- IDLE with `start`=1 and `op`≤4: capture `a`, `b`, `op`; set k=0 and carry reg=0; go to RUN. A `start` with `op` 5–7 is ignored: no state change and no `done`.
- RUN, word k:
  - `alu_a`/`alu_b` drive word k of the captured operands.
  - `alu_cs` maps ADD→AC_AD, SUB→AC_SB, LT→AC_SB, AND→AC_AN, OR→AC_OR.
  - `alu_cin` = carry reg for ADD/SUB/LT, 0 for AND/OR.
  - At the edge: result word k ← `alu_s`; carry reg ← `alu_cout` (0 for AND/OR); zero accumulator ANDs in `alu_zero`; k increments.
- Leaving RUN after k=W-1:
  - `carry` ← carry reg.
  - For MW_LT only: `result` ← zero-extended final borrow (1 iff a<b unsigned), and `zero` ← ~borrow.
- IDLE and DONE drive `alu_a`=0, `alu_b`=0, `alu_cin`=0, `alu_cs`=AC_AN. This keeps the ALU away from its undefined default case.
- `start` in RUN or DONE is ignored. Operand inputs may change freely after acceptance.
- `rst` in any state: go to IDLE at the next edge and abort the in-flight operation; no `done` is issued.
- Reset values: `busy` 0, `done` 0, `result` 0, `carry` 0, `zero` 1, `ovf` 0, state IDLE, k 0.

## Timing
- `start` accepted at edge t → `busy` high from t+1 → `done` high for cycle t+W+1 → IDLE at t+W+2.
- Minimum start-to-start spacing is W+2 cycles.
- ALU path is combinational within one cycle: registered operand word → `alu` → registered result word. The block is one ALU delay deep.
- `result`, `carry`, `zero`, `ovf` update only at RUN edges and the RUN→DONE edge. They are stable during DONE and IDLE.

## Configuration
- `MWSEQ_OVF_EN` defined:
  - `ovf` port exists and is registered on RUN→DONE from the top word.
  - ADD: sign(a)==sign(b) and sign(s)≠sign(a).
  - SUB and LT: sign(a)≠sign(b) and sign(s)≠sign(a).
  - AND/OR: `ovf` = 0.
- Not defined: no `ovf` port and no sign-bit logic.

## Structure
- Shared package holds:
  - AC_* ALU op codes and AC_N
  - MW_* op codes and their 3-bit width
  - state encoding (IDLE/RUN/DONE)
- Natural sub-module: `mword_shreg`. It holds the W·N operand pair, loads on accept, and shifts right by N each RUN cycle, presenting word 0 as the current word.
- Result assembly uses the same shift-in scheme.

## Test plan
With N=8, W=4:
- ADD 0x000000FF+0x00000001 at t → `done` at t+5, `result` 0x00000100, `carry` 0, `zero` 0.
- ADD 0xFFFFFFFF+0x00000001 → `result` 0, `carry` 1, `zero` 1. With MWSEQ_OVF_EN: ADD 0x7FFFFFFF+1 → 0x80000000, `ovf` 1.
- SUB 0x00000000−0x00000001 → 0xFFFFFFFF, `carry` 1, `ovf` 0. SUB 0x12345678−0x12345678 → 0, `zero` 1.
- LT 0x0000FFFF vs 0x00010000 → `result` 1, `zero` 0. Swapped operands → `result` 0, `zero` 1, `carry` 0.
- AND 0xF0F0F0F0&0xFF00FF00 → 0xF000F000, `carry` 0. OR of the same operands → 0xFFF0FFF0. `op`=6 → no `busy`, no `done`.
- Mid-RUN: `start` with new operands is ignored and the first result is returned. Separately, `rst` at RUN k=2 → `busy` 0 next cycle, no `done`, `result` 0, `zero` 1.
